// File: rtl/cv32e40p_obi_instr_mem_responder.sv
// ----------------------------------------------------------------------------
// cv32e40p_obi_instr_mem_responder
//
// OBI instruction-side memory responder for cv32e40p simulation and FPGA
// bring-up. It holds a word-addressed array and answers fetches with a
// configurable grant delay, response latency and outstanding depth. It also
// reports misaligned or out-of-range fetches as error responses, and it has
// a backdoor port for loading program images.
//
// Ports
//   clk_i           clock
//   rst_n           asynchronous active-low reset (synchronous release)
//   instr_req_i     fetch request
//   instr_addr_i    fetch byte address, stable while req is high and ungranted
//   instr_gnt_o     grant (combinational)
//   instr_rvalid_o  response valid, one cycle per accepted fetch, in order
//   instr_rdata_o   response data, zero when rvalid is low or on error
//   instr_err_o     error qualifier, valid with rvalid
//   gnt_stall_i     forces the grant low while high
//   ld_we_i         backdoor write enable
//   ld_addr_i       backdoor word index
//   ld_data_i       backdoor write data
//   outstanding_o   accepted fetches not yet answered
//   err_cnt_o       saturating count of error responses
// ----------------------------------------------------------------------------
module cv32e40p_obi_instr_mem_responder #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned MAX_OUT     = 4,
    parameter int unsigned GNT_DELAY   = 0,
    parameter int unsigned RSP_LATENCY = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [DATA_W-1:0]            instr_rdata_o,
    output logic                         instr_err_o,
    input  logic                         gnt_stall_i,
    input  logic                         ld_we_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr_i,
    input  logic [DATA_W-1:0]            ld_data_i,
    output logic [3:0]                   outstanding_o,
    output logic [15:0]                  err_cnt_o
);

    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam int unsigned OFF_W  = $clog2(DATA_W / 8);
    localparam int unsigned WORD_W = 32 - OFF_W;
    localparam int unsigned PTR_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    // With a one-cycle latency the fetch is answered straight from the
    // accept edge and never sits in the queue.
    localparam bit          BYPASS = (RSP_LATENCY == 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("DATA_W must be 32 or 64");
    end
    if (MAX_OUT < 1 || MAX_OUT > 8) begin : g_bad_max_out
        $error("MAX_OUT must be in 1..8");
    end
    if (RSP_LATENCY < 1 || RSP_LATENCY > 7) begin : g_bad_latency
        $error("RSP_LATENCY must be in 1..7");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [DATA_W-1:0] q_data [MAX_OUT];
    logic [2:0]        q_age  [MAX_OUT];
    logic [MAX_OUT-1:0] q_err;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [3:0]        q_cnt;

    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [3:0]        outstanding_q;
    logic [15:0]       err_cnt_q;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic              hold_ok;
    logic              room;
    logic              accept;
    logic [WORD_W-1:0] word_addr;
    logic [IDX_W-1:0]  mem_idx;
    logic              cap_err;
    logic [DATA_W-1:0] cap_data;
    logic              head_due;
    logic              bypass;
    logic              push;
    logic              rsp_fire;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------
    // The full check uses the registered count, so a response retiring in
    // the current cycle does not open a slot until the next cycle.
    assign room        = (outstanding_q < 4'(MAX_OUT));
    assign instr_gnt_o = rst_n & instr_req_i & ~gnt_stall_i & room & hold_ok;
    assign accept      = instr_req_i & instr_gnt_o;

    if (GNT_DELAY == 0) begin : g_no_delay
        assign hold_ok = 1'b1;
    end else begin : g_delay
        localparam int unsigned HOLD_W = $clog2(GNT_DELAY + 1);
        logic [HOLD_W-1:0] hold_cnt;

        // A stall restarts the delay, so after a stall the request must
        // again be held GNT_DELAY cycles before it is granted.
        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n) begin
                hold_cnt <= '0;
            end else if (!instr_req_i || accept || gnt_stall_i) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_W'(GNT_DELAY)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end

        assign hold_ok = (hold_cnt == HOLD_W'(GNT_DELAY));
    end

    // ------------------------------------------------------------------
    // Address decode and data capture
    // ------------------------------------------------------------------
    assign word_addr = instr_addr_i[31:OFF_W];
    assign mem_idx   = word_addr[IDX_W-1:0];
    assign cap_err   = (|instr_addr_i[OFF_W-1:0]) || (word_addr >= WORD_W'(MEM_DEPTH));
    assign cap_data  = cap_err ? '0 : mem[mem_idx];

    // Backdoor loader. The accept path reads mem combinationally before this
    // edge updates it, so a same-edge fetch of the same word sees old data.
    always_ff @(posedge clk_i) begin
        if (ld_we_i) begin
            mem[ld_addr_i] <= ld_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Response selection
    // ------------------------------------------------------------------
    // An entry's stored age is the number of edges since it was pushed. It
    // reaches RSP_LATENCY-1 on this edge when stored age + 1 >= RSP_LATENCY-1.
    always_comb begin
        head_due = 1'b0;
        if (q_cnt != 4'd0) begin
            head_due = (({1'b0, q_age[rd_ptr]} + 4'd2) >= 4'(RSP_LATENCY));
        end
        bypass   = BYPASS && accept && (q_cnt == 4'd0);
        push     = accept && !bypass;
        rsp_fire = head_due || bypass;
        rsp_data = head_due ? q_data[rd_ptr] : cap_data;
        rsp_err  = head_due ? q_err[rd_ptr]  : cap_err;
    end

    // ------------------------------------------------------------------
    // In-order response queue
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            q_cnt  <= '0;
            q_err  <= '0;
            for (int unsigned i = 0; i < MAX_OUT; i++) begin
                q_data[i] <= '0;
                q_age[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < MAX_OUT; i++) begin
                if (q_age[i] != 3'd7) begin
                    q_age[i] <= q_age[i] + 3'd1;
                end
            end
            if (push) begin
                q_data[wr_ptr] <= cap_data;
                q_err[wr_ptr]  <= cap_err;
                q_age[wr_ptr]  <= '0;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (head_due) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            q_cnt <= q_cnt + {3'b000, push} - {3'b000, head_due};
        end
    end

    // ------------------------------------------------------------------
    // Registered response and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            outstanding_q <= '0;
            err_cnt_q     <= '0;
        end else begin
            rvalid_q <= rsp_fire;
            rdata_q  <= rsp_fire ? rsp_data : '0;
            err_q    <= rsp_fire & rsp_err;
            // A fetch stays outstanding until its rvalid cycle has completed.
            case ({accept, rvalid_q})
                2'b10:   outstanding_q <= outstanding_q + 4'd1;
                2'b01:   outstanding_q <= outstanding_q - 4'd1;
                default: outstanding_q <= outstanding_q;
            endcase
            if (rsp_fire && rsp_err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign instr_rvalid_o = rvalid_q;
    assign instr_rdata_o  = rdata_q;
    assign instr_err_o    = err_q;
    assign outstanding_o  = outstanding_q;
    assign err_cnt_o      = err_cnt_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    // Every outstanding fetch is either queued or currently on rvalid.
    a_out_consistent: assert property (@(posedge clk_i) disable iff (!rst_n)
        outstanding_q == (q_cnt + {3'b000, rvalid_q}));
    a_out_bounded: assert property (@(posedge clk_i) disable iff (!rst_n)
        outstanding_q <= 4'(MAX_OUT));

endmodule

// File: tb/tb_cv32e40p_obi_instr_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_cv32e40p_obi_instr_mem_responder
//
// Directed bench for the OBI instruction memory responder. Four instances
// share address, stall and loader inputs, each with its own request line:
//   [0] defaults           (MAX_OUT=4, GNT_DELAY=0, RSP_LATENCY=1)
//   [1] shallow and slow   (MAX_OUT=2, RSP_LATENCY=4)
//   [2] delayed grant      (GNT_DELAY=2)
//   [3] long latency       (RSP_LATENCY=7)
// Inputs change at the falling edge; outputs are sampled 1 ns later.
// ----------------------------------------------------------------------------
module tb_cv32e40p_obi_instr_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        stall;
    logic        ld_we;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    logic        req    [4];
    logic        gnt    [4];
    logic        rvalid [4];
    logic        err    [4];
    logic [31:0] rdata  [4];
    logic [3:0]  outst  [4];
    logic [15:0] errcnt [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        cv32e40p_obi_instr_mem_responder #(
            .DATA_W      (32),
            .MEM_DEPTH   (1024),
            .MAX_OUT     ((g == 1) ? 2 : 4),
            .GNT_DELAY   ((g == 2) ? 2 : 0),
            .RSP_LATENCY ((g == 1) ? 4 : ((g == 3) ? 7 : 1))
        ) u_dut (
            .clk_i          (clk),
            .rst_n          (rst_n),
            .instr_req_i    (req[g]),
            .instr_addr_i   (addr),
            .instr_gnt_o    (gnt[g]),
            .instr_rvalid_o (rvalid[g]),
            .instr_rdata_o  (rdata[g]),
            .instr_err_o    (err[g]),
            .gnt_stall_i    (stall),
            .ld_we_i        (ld_we),
            .ld_addr_i      (ld_addr),
            .ld_data_i      (ld_data),
            .outstanding_o  (outst[g]),
            .err_cnt_o      (errcnt[g])
        );
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic load(input int idx, input logic [31:0] val);
        @(negedge clk);
        ld_we   = 1'b1;
        ld_addr = 10'(idx);
        ld_data = val;
        @(posedge clk);
        #1;
        ld_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        addr = '0; stall = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        for (int g = 0; g < 4; g++) req[g] = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            total++; if (gnt[g] !== 1'b0) begin bad++; $display("FAIL reset_gnt[%0d] act=%b exp=0", g, gnt[g]); end
            total++; if (rvalid[g] !== 1'b0) begin bad++; $display("FAIL reset_rvalid[%0d] act=%b exp=0", g, rvalid[g]); end
            total++; if (rdata[g] !== 32'h0) begin bad++; $display("FAIL reset_rdata[%0d] act=%h exp=0", g, rdata[g]); end
            total++; if (err[g] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d] act=%b exp=0", g, err[g]); end
            total++; if (outst[g] !== 4'd0) begin bad++; $display("FAIL reset_outst[%0d] act=%0d exp=0", g, outst[g]); end
            total++; if (errcnt[g] !== 16'd0) begin bad++; $display("FAIL reset_errcnt[%0d] act=%0d exp=0", g, errcnt[g]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic preload();
        for (int i = 0; i < 4; i++) load(i, 32'h11 * (i + 1));
        load(5, 32'h55);
    endtask

    // Four back-to-back fetches on the default instance.
    task automatic test_burst();
        logic        exp_g, exp_v;
        logic [31:0] exp_d;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req[0] = (i < 4);
            addr   = 32'(4 * i);
            #1;
            exp_g = (i < 4);
            exp_v = (i >= 1 && i <= 4);
            exp_d = exp_v ? 32'h11 * i : 32'h0;
            total++; if (gnt[0] !== exp_g) begin bad++; $display("FAIL burst_gnt c%0d act=%b exp=%b", i, gnt[0], exp_g); end
            total++; if (rvalid[0] !== exp_v) begin bad++; $display("FAIL burst_rvalid c%0d act=%b exp=%b", i, rvalid[0], exp_v); end
            total++; if (rdata[0] !== exp_d) begin bad++; $display("FAIL burst_rdata c%0d act=%h exp=%h", i, rdata[0], exp_d); end
            total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL burst_err c%0d act=%b exp=0", i, err[0]); end
            total++; if (outst[0] !== 4'(exp_v)) begin bad++; $display("FAIL burst_outst c%0d act=%0d exp=%0d", i, outst[0], exp_v); end
        end
    endtask

    // MAX_OUT=2, RSP_LATENCY=4 with req held: grant blocks while two are in flight.
    task automatic test_full();
        bit [0:10]   gpat = 11'b11000110001;
        bit [0:10]   vpat = 11'b00001100011;
        int          opat [11] = '{0, 1, 2, 2, 2, 1, 1, 2, 2, 2, 1};
        logic [31:0] exp_d;
        int          peak = 0;
        int          n = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            req[1] = 1'b1;
            addr   = 32'h0;
            #1;
            if (int'(outst[1]) > peak) peak = int'(outst[1]);
            exp_d = vpat[i] ? 32'h11 : 32'h0;
            total++; if (gnt[1] !== gpat[i]) begin bad++; $display("FAIL full_gnt c%0d act=%b exp=%b", i, gnt[1], gpat[i]); end
            total++; if (rvalid[1] !== vpat[i]) begin bad++; $display("FAIL full_rvalid c%0d act=%b exp=%b", i, rvalid[1], vpat[i]); end
            total++; if (rdata[1] !== exp_d) begin bad++; $display("FAIL full_rdata c%0d act=%h exp=%h", i, rdata[1], exp_d); end
            total++; if (outst[1] !== 4'(opat[i])) begin bad++; $display("FAIL full_outst c%0d act=%0d exp=%0d", i, outst[1], opat[i]); end
        end
        req[1] = 1'b0;
        total++; if (peak !== 2) begin bad++; $display("FAIL full_peak act=%0d exp=2", peak); end
        while ((outst[1] !== 4'd0 || rvalid[1] !== 1'b0) && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++; if (outst[1] !== 4'd0 || rvalid[1] !== 1'b0) begin bad++; $display("FAIL full_drain outst=%0d rvalid=%b exp=0/0", outst[1], rvalid[1]); end
    endtask

    // GNT_DELAY=2 with a 3-cycle stall between two fetches.
    task automatic test_stall();
        bit [0:9]    gpat = 10'b0010000010;
        bit [0:9]    vpat = 10'b0001000001;
        logic [31:0] exp_d;
        int          acc4 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req[2] = (i < 9);
            addr   = (i >= 3) ? 32'h4 : 32'h0;
            stall  = (i >= 3 && i <= 5);
            #1;
            if (req[2] && gnt[2] && addr == 32'h4) acc4++;
            exp_d = (i == 3) ? 32'h11 : ((i == 9) ? 32'h22 : 32'h0);
            total++; if (gnt[2] !== gpat[i]) begin bad++; $display("FAIL stall_gnt c%0d act=%b exp=%b", i, gnt[2], gpat[i]); end
            total++; if (rvalid[2] !== vpat[i]) begin bad++; $display("FAIL stall_rvalid c%0d act=%b exp=%b", i, rvalid[2], vpat[i]); end
            total++; if (rdata[2] !== exp_d) begin bad++; $display("FAIL stall_rdata c%0d act=%h exp=%h", i, rdata[2], exp_d); end
        end
        stall = 1'b0;
        total++; if (acc4 !== 1) begin bad++; $display("FAIL stall_accepts act=%0d exp=1", acc4); end
    endtask

    // Misaligned and out-of-range fetches.
    task automatic test_err();
        logic [31:0] a [2] = '{32'h2, 32'd4096};
        logic        exp_v;
        int          exp_c [4] = '{0, 1, 2, 2};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req[0] = (i < 2);
            addr   = (i < 2) ? a[i] : 32'h0;
            #1;
            exp_v = (i == 1 || i == 2);
            if (i < 2) begin
                total++; if (gnt[0] !== 1'b1) begin bad++; $display("FAIL err_gnt c%0d act=%b exp=1", i, gnt[0]); end
            end
            total++; if (rvalid[0] !== exp_v) begin bad++; $display("FAIL err_rvalid c%0d act=%b exp=%b", i, rvalid[0], exp_v); end
            total++; if (err[0] !== exp_v) begin bad++; $display("FAIL err_flag c%0d act=%b exp=%b", i, err[0], exp_v); end
            total++; if (rdata[0] !== 32'h0) begin bad++; $display("FAIL err_rdata c%0d act=%h exp=0", i, rdata[0]); end
            total++; if (errcnt[0] !== 16'(exp_c[i])) begin bad++; $display("FAIL err_cnt c%0d act=%0d exp=%0d", i, errcnt[0], exp_c[i]); end
        end
    endtask

    // Loader write on the same edge as a fetch of the same word.
    task automatic test_loader_rbw();
        @(negedge clk);
        req[0] = 1'b1; addr = 32'h14;
        ld_we = 1'b1; ld_addr = 10'd5; ld_data = 32'hAA;
        #1;
        total++; if (gnt[0] !== 1'b1) begin bad++; $display("FAIL rbw_gnt act=%b exp=1", gnt[0]); end
        @(negedge clk);
        req[0] = 1'b0; ld_we = 1'b0;
        #1;
        total++; if (rvalid[0] !== 1'b1) begin bad++; $display("FAIL rbw_rvalid act=%b exp=1", rvalid[0]); end
        total++; if (rdata[0] !== 32'h55) begin bad++; $display("FAIL rbw_old_data act=%h exp=55", rdata[0]); end
        @(negedge clk);
        req[0] = 1'b1; addr = 32'h14;
        @(negedge clk);
        req[0] = 1'b0;
        #1;
        total++; if (rdata[0] !== 32'hAA) begin bad++; $display("FAIL rbw_new_data act=%h exp=aa", rdata[0]); end
    endtask

    // Reset with three fetches pending on the long-latency instance.
    task automatic test_rst_mid();
        int seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req[3] = 1'b1;
            addr   = 32'(4 * i);
            #1;
            total++; if (gnt[3] !== 1'b1) begin bad++; $display("FAIL rst_gnt c%0d act=%b exp=1", i, gnt[3]); end
        end
        @(negedge clk);
        #1;
        total++; if (outst[3] !== 4'd3) begin bad++; $display("FAIL rst_pending act=%0d exp=3", outst[3]); end
        total++; if (rvalid[3] !== 1'b0) begin bad++; $display("FAIL rst_early_rvalid act=%b exp=0", rvalid[3]); end
        rst_n = 1'b0;
        #1;
        total++; if (gnt[3] !== 1'b0) begin bad++; $display("FAIL rst_async_gnt act=%b exp=0", gnt[3]); end
        total++; if (outst[3] !== 4'd0) begin bad++; $display("FAIL rst_async_outst act=%0d exp=0", outst[3]); end
        total++; if (errcnt[0] !== 16'd0) begin bad++; $display("FAIL rst_async_errcnt act=%0d exp=0", errcnt[0]); end
        req[3] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (rvalid[3] !== 1'b0 || outst[3] !== 4'd0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_stale_rsp act=%0d exp=0", seen); end
        // Memory survives reset.
        @(negedge clk);
        req[0] = 1'b1; addr = 32'h8;
        @(negedge clk);
        addr = 32'h14;
        #1;
        total++; if (rdata[0] !== 32'h33) begin bad++; $display("FAIL rst_mem2 act=%h exp=33", rdata[0]); end
        @(negedge clk);
        req[0] = 1'b0;
        #1;
        total++; if (rdata[0] !== 32'hAA) begin bad++; $display("FAIL rst_mem5 act=%h exp=aa", rdata[0]); end
    endtask

    initial begin
        test_reset();
        preload();
        test_burst();
        test_full();
        test_stall();
        test_err();
        test_loader_rbw();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
